// File: rtl/fb_ddram_writer.sv
// fb_ddram_writer
//   Streams 32bpp pixels into the DDRAM framebuffer scanned out by the scaler.
//   The block packs pixel pairs into 64-bit words and buffers them in a FIFO.
//   It then issues fixed-length Avalon-MM burst writes on the DDRAM port.
//
// Ports
//   clk_sys         in   system clock (DDRAM_CLK is driven from it)
//   rst             in   synchronous reset, active high
//   frame_start     in   1-cycle pulse: restart the frame at BASE_ADDR
//   pix_valid       in   pix_data valid
//   pix_ready       out  pixel accepted when pix_valid & pix_ready
//   pix_data [31:0] in   pixel {A,B,G,R}, byte 0 = R
//   ddram_busy      in   DDRAM waitrequest
//   ddram_burstcnt  out  burst length in words
//   ddram_addr      out  64-bit word address, held for the whole burst
//   ddram_din       out  write data; advances only on an accepted beat
//   ddram_be        out  byte enables, always all ones
//   ddram_we        out  write request, high for the whole burst
//   ddram_rd        out  read request, always 0
//   frame_done      out  1-cycle pulse after the last beat of a frame
//
// Handshakes: a pixel transfers on a clock edge where pix_valid & pix_ready
// are both high. A DDRAM beat transfers on an edge where ddram_we is high
// and ddram_busy is low. Outputs are held unchanged while a transfer is
// pending.

module fb_ddram_writer #(
  parameter int          WIDTH      = 1280,
  parameter int          HEIGHT     = 720,
  parameter logic [28:0] BASE_ADDR  = 29'h0600000,
  parameter int          BURST      = 64,
  parameter int          FIFO_DEPTH = 128
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [31:0] pix_data,
  input  logic        ddram_busy,
  output logic [7:0]  ddram_burstcnt,
  output logic [28:0] ddram_addr,
  output logic [63:0] ddram_din,
  output logic [7:0]  ddram_be,
  output logic        ddram_we,
  output logic        ddram_rd,
  output logic        frame_done
);

  localparam int TOTAL_PIX   = WIDTH * HEIGHT;
  localparam int TOTAL_WORDS = TOTAL_PIX / 2;
  localparam int PW          = $clog2(TOTAL_PIX + 1);
  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam int LW          = AW + 1;

  localparam logic [PW-1:0] TOTAL_PIX_L = PW'(TOTAL_PIX);
  localparam logic [LW-1:0] BURST_L     = LW'(BURST);
  localparam logic [LW-1:0] DEPTH_L     = LW'(FIFO_DEPTH);
  localparam logic [7:0]    BEAT_LAST   = 8'(BURST - 1);
  localparam logic [18:0]   BURST_W     = 19'(BURST);
  localparam logic [18:0]   LAST_OFF    = 19'(TOTAL_WORDS - BURST);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [63:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          half;      // first pixel of a pair is held in pix_lo
  logic [31:0]   pix_lo;
  logic [PW-1:0] pix_cnt;   // pixels accepted in the current frame
  logic [7:0]    beat_cnt;  // beats accepted in the current burst
  logic [18:0]   word_off;  // word offset of the next burst within the frame

  logic pix_fire, push, beat_ok, last_beat, last_burst, clear, start_burst;

  assign pix_ready  = (state == S_RUN) && (level != DEPTH_L) && (pix_cnt < TOTAL_PIX_L);
  assign pix_fire   = pix_valid & pix_ready;
  assign push       = pix_fire & half;
  assign beat_ok    = ddram_we & ~ddram_busy;
  assign last_beat  = beat_ok && (beat_cnt == BEAT_LAST);
  assign last_burst = (word_off == LAST_OFF);

  assign ddram_be  = 8'hFF;
  assign ddram_rd  = 1'b0;
  // The FIFO head is presented only during a burst so that idle output is 0.
  assign ddram_din = ddram_we ? mem[rd_ptr] : 64'd0;

  // clear wipes the FIFO, the half-pair and the frame counters.
  // A restart during a burst waits in DRAIN. The exception is a restart that
  // coincides with the final beat, because that burst ends on the same edge.
  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (frame_start) begin
          state_nxt = S_RUN;
          clear     = 1'b1;
        end
      end
      S_RUN: begin
        if (frame_start) begin
          if (ddram_we && !last_beat) state_nxt = S_DRAIN;
          else                        clear     = 1'b1;
        end else if (last_beat && last_burst) begin
          state_nxt = S_DONE;
        end
      end
      S_DRAIN: begin
        if (last_beat) begin
          state_nxt = S_RUN;
          clear     = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign start_burst = (state == S_RUN) && !ddram_we && !clear && (level >= BURST_L);

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state          <= S_IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      half           <= 1'b0;
      pix_lo         <= 32'd0;
      pix_cnt        <= '0;
      beat_cnt       <= 8'd0;
      word_off       <= 19'd0;
      ddram_we       <= 1'b0;
      ddram_addr     <= 29'd0;
      ddram_burstcnt <= 8'd0;
      frame_done     <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= (state == S_RUN) && (state_nxt == S_DONE);

      if (start_burst) begin
        ddram_we       <= 1'b1;
        ddram_addr     <= BASE_ADDR + {10'd0, word_off};
        ddram_burstcnt <= 8'(BURST);
        beat_cnt       <= 8'd0;
      end else if (beat_ok) begin
        if (last_beat) begin
          ddram_we <= 1'b0;
          beat_cnt <= 8'd0;
          word_off <= word_off + BURST_W;
        end else begin
          beat_cnt <= beat_cnt + 8'd1;
        end
      end

      if (clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        level    <= '0;
        half     <= 1'b0;
        pix_cnt  <= '0;
        word_off <= 19'd0;
      end else begin
        if (pix_fire) begin
          pix_cnt <= pix_cnt + 1'b1;
          half    <= ~half;
          if (!half) pix_lo <= pix_data;
        end
        if (push)    wr_ptr <= wr_ptr + 1'b1;
        if (beat_ok) rd_ptr <= rd_ptr + 1'b1;
        case ({push, beat_ok})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end
    end
  end

  // The FIFO storage has no reset. Words become visible only through level.
  always_ff @(posedge clk_sys) begin
    if (push && !clear) mem[wr_ptr] <= {pix_data, pix_lo};
  end

endmodule

// File: tb/tb_fb_ddram_writer.sv
// tb_fb_ddram_writer
//   Bench for fb_ddram_writer, using a reduced 64x16 frame (8 bursts of 64).
//   A reference model pairs accepted pixels into expected words.
//   Every accepted beat is checked against that model for data, address and
//   burst length.
module tb_fb_ddram_writer;
  localparam int          WIDTH      = 64;
  localparam int          HEIGHT     = 16;
  localparam int          BURST      = 64;
  localparam int          FIFO_DEPTH = 128;
  localparam logic [28:0] BASE       = 29'h0600000;
  localparam int          NB         = WIDTH * HEIGHT / 2 / BURST;

  logic        clk_sys, rst, frame_start, pix_valid, pix_ready, ddram_busy;
  logic [31:0] pix_data;
  logic [7:0]  ddram_burstcnt, ddram_be;
  logic [28:0] ddram_addr;
  logic [63:0] ddram_din;
  logic        ddram_we, ddram_rd, frame_done;

  fb_ddram_writer #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BASE_ADDR(BASE),
    .BURST(BURST), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_sys(clk_sys), .rst(rst), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .ddram_busy(ddram_busy), .ddram_burstcnt(ddram_burstcnt),
    .ddram_addr(ddram_addr), .ddram_din(ddram_din), .ddram_be(ddram_be),
    .ddram_we(ddram_we), .ddram_rd(ddram_rd), .frame_done(frame_done)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] exp_q[$];
  logic [31:0] m_lo = 32'd0;
  bit          m_half = 1'b0;
  int          m_beat = 0;
  int          m_burst_no = 0;
  bit          m_restart_pend = 1'b0;
  int          cyc = 0;
  int          total_beats = 0;
  int          total_bursts = 0;
  int          done_cnt = 0;
  int          exp_done_cyc = -1;
  int          last_accept_cyc = 0;
  int          we_rise_cyc = 0;
  bit          prev_we = 1'b0;
  bit          stall_prev = 1'b0;
  logic [63:0] stall_din = 64'd0;
  logic [28:0] stall_addr = 29'd0;
  logic [28:0] last_burst_addr = 29'd0;
  logic [63:0] first_din = 64'd0;
  logic [63:0] last_din = 64'd0;

  int busy_mode = 0;   // 0 low, 1 toggle, 2 random pct, 3 held high
  int busy_pct  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- busy driver ----------------
  initial begin
    ddram_busy = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      case (busy_mode)
        0:       ddram_busy = 1'b0;
        1:       ddram_busy = ~ddram_busy;
        2:       ddram_busy = (int'($urandom_range(99)) < busy_pct);
        default: ddram_busy = 1'b1;
      endcase
    end
  end

  // ---------------- monitor + reference model ----------------
  initial begin
    forever begin
      @(negedge clk_sys);
      cyc++;
      if (!rst) begin
        if (stall_prev) begin
          chk("stall_we", {63'd0, ddram_we}, 64'd1);
          chk("stall_din", ddram_din, stall_din);
          chk("stall_addr", {35'd0, ddram_addr}, {35'd0, stall_addr});
        end
        stall_prev = ddram_we && ddram_busy;
        if (stall_prev) begin
          stall_din  = ddram_din;
          stall_addr = ddram_addr;
        end
        if (ddram_we && !prev_we) we_rise_cyc = cyc;
        prev_we = ddram_we;

        if (pix_valid && pix_ready) begin
          last_accept_cyc = cyc;
          if (m_half) begin
            exp_q.push_back({pix_data, m_lo});
            m_half = 1'b0;
          end else begin
            m_lo   = pix_data;
            m_half = 1'b1;
          end
        end

        if (ddram_we && !ddram_busy) begin
          if (exp_q.size() == 0) chk("beat_unexpected", 64'd1, 64'd0);
          else chk("beat_din", ddram_din, exp_q.pop_front());
          chk("beat_addr", {35'd0, ddram_addr}, {35'd0, BASE + 29'(m_burst_no * BURST)});
          chk("beat_burstcnt", {56'd0, ddram_burstcnt}, 64'(BURST));
          if (m_beat == 0) first_din = ddram_din;
          m_beat++;
          total_beats++;
          if (m_beat == BURST) begin
            last_din        = ddram_din;
            last_burst_addr = ddram_addr;
            m_beat          = 0;
            total_bursts++;
            if (m_restart_pend) begin
              m_burst_no     = 0;
              m_restart_pend = 1'b0;
            end else begin
              m_burst_no++;
              if (m_burst_no == NB) begin
                exp_done_cyc = cyc + 1;
                m_burst_no   = 0;
              end
            end
          end
        end

        if (frame_done) begin
          done_cnt++;
          chk("frame_done_cycle", 64'(cyc), 64'(exp_done_cyc));
        end else if (cyc == exp_done_cyc) begin
          chk("frame_done_missing", 64'd0, 64'd1);
        end

        // A restart lets the burst in progress finish and drops everything else.
        if (frame_start) begin
          if (m_beat > 0) begin
            while (exp_q.size() > BURST - m_beat) void'(exp_q.pop_back());
            m_restart_pend = 1'b1;
          end else begin
            exp_q.delete();
            m_burst_no = 0;
          end
          m_half = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(posedge clk_sys); #1;
    frame_start = 1'b1;
    @(negedge clk_sys);
    @(posedge clk_sys); #1;
    frame_start = 1'b0;
  endtask

  task automatic send_pix(input int n, input bit rnd, input logic [31:0] base);
    int sent = 0;
    int guard = 0;
    bit need = 1'b1;
    logic [31:0] cur = 32'd0;
    while (sent < n && guard < 20000) begin
      @(posedge clk_sys); #1;
      if (need) begin
        cur  = rnd ? $urandom : base + 32'(sent);
        need = 1'b0;
      end
      pix_data  = cur;
      pix_valid = 1'b1;
      @(negedge clk_sys);
      guard++;
      if (pix_ready) begin
        sent++;
        need = 1'b1;
      end
    end
    @(posedge clk_sys); #1;
    pix_valid = 1'b0;
    chk("send_count", 64'(sent), 64'(n));
  endtask

  task automatic wait_drain();
    int g = 0;
    int quiet = 0;
    while (quiet < 8 && g < 5000) begin
      @(negedge clk_sys);
      g++;
      if (exp_q.size() < BURST && m_beat == 0 && !ddram_we) quiet++;
      else quiet = 0;
    end
    chk("drain_timeout", 64'(quiet), 64'd8);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          n_pix;
    int          mode;
    int          pct;
    int          exp_beats;
    int          exp_left;
    logic [28:0] exp_last_addr;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int b0, d0, acc, g;
    bit need;

    vecs[0] = '{128, 1, 0, 64, 0, 29'h0600000};
    vecs[1] = '{300, 2, 50, 128, 22, 29'h0600040};
    vecs[2] = '{257, 2, 25, 128, 0, 29'h0600040};
    vecs[3] = '{640, 2, 75, 320, 0, 29'h0600100};

    rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_data = 32'd0;
    repeat (3) @(posedge clk_sys);
    #1 rst = 1'b0;

    // T1: reset state
    @(negedge clk_sys);
    chk("rst_pix_ready", {63'd0, pix_ready}, 64'd0);
    chk("rst_we", {63'd0, ddram_we}, 64'd0);
    chk("rst_rd", {63'd0, ddram_rd}, 64'd0);
    chk("rst_be", {56'd0, ddram_be}, 64'hFF);
    chk("rst_frame_done", {63'd0, frame_done}, 64'd0);
    chk("rst_addr", {35'd0, ddram_addr}, 64'd0);
    chk("rst_din", ddram_din, 64'd0);
    chk("rst_burstcnt", {56'd0, ddram_burstcnt}, 64'd0);

    // T2: single burst, sequential pixels, no busy
    @(posedge clk_sys); #1;
    frame_start = 1'b1;
    @(negedge clk_sys);
    chk("ready_during_start", {63'd0, pix_ready}, 64'd0);
    @(posedge clk_sys); #1;
    frame_start = 1'b0;
    @(negedge clk_sys);
    chk("ready_after_start", {63'd0, pix_ready}, 64'd1);
    b0 = total_bursts;
    send_pix(128, 1'b0, 32'd0);
    wait_drain();
    chk("t2_bursts", 64'(total_bursts - b0), 64'd1);
    chk("t2_addr", {35'd0, last_burst_addr}, {35'd0, 29'h0600000});
    chk("t2_beat0", first_din, 64'h00000001_00000000);
    chk("t2_beat63", last_din, 64'h0000007F_0000007E);
    chk("t2_we_rise_delay", 64'(we_rise_cyc - last_accept_cyc), 64'd2);

    // Table: restart in RUN, then stream with various busy patterns
    for (int i = 0; i < 4; i++) begin
      busy_mode = vecs[i].mode;
      busy_pct  = vecs[i].pct;
      pulse_start();
      b0 = total_beats;
      send_pix(vecs[i].n_pix, 1'b1, 32'd0);
      wait_drain();
      chk("vec_beats", 64'(total_beats - b0), 64'(vecs[i].exp_beats));
      chk("vec_leftover", 64'(exp_q.size()), 64'(vecs[i].exp_left));
      chk("vec_last_addr", {35'd0, last_burst_addr}, {35'd0, vecs[i].exp_last_addr});
    end

    // T4: held busy fills the FIFO, then release
    busy_mode = 3;
    pulse_start();
    b0 = total_beats;
    acc = 0;
    need = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk_sys); #1;
      if (need) begin
        pix_data = $urandom;
        need = 1'b0;
      end
      pix_valid = 1'b1;
      @(negedge clk_sys);
      if (pix_ready) begin
        acc++;
        need = 1'b1;
      end
    end
    chk("t4_full_px", 64'(acc), 64'd256);
    chk("t4_ready_full", {63'd0, pix_ready}, 64'd0);
    chk("t4_no_beats", 64'(total_beats - b0), 64'd0);
    @(posedge clk_sys); #1;
    pix_valid = 1'b0;
    busy_mode = 0;
    send_pix(256, 1'b1, 32'd0);
    wait_drain();
    chk("t4_beats", 64'(total_beats - b0), 64'd256);
    chk("t4_leftover", 64'(exp_q.size()), 64'd0);

    // T5: full frame
    busy_mode = 2;
    busy_pct  = 30;
    pulse_start();
    d0 = done_cnt;
    b0 = total_bursts;
    send_pix(WIDTH * HEIGHT, 1'b1, 32'd0);
    g = 0;
    while (done_cnt == d0 && g < 5000) begin
      @(negedge clk_sys);
      g++;
    end
    repeat (4) @(negedge clk_sys);
    chk("t5_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("t5_bursts", 64'(total_bursts - b0), 64'(NB));
    chk("t5_last_addr", {35'd0, last_burst_addr}, {35'd0, 29'h06001C0});
    chk("t5_leftover", 64'(exp_q.size()), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_sys); #1;
      pix_valid = 1'b1;
      @(negedge clk_sys);
      chk("t5_ready_done", {63'd0, pix_ready}, 64'd0);
    end
    @(posedge clk_sys); #1;
    pix_valid = 1'b0;

    // T6: restart mid-burst from DONE-started frame
    busy_mode = 3;
    pulse_start();
    send_pix(192, 1'b1, 32'd0);
    busy_mode = 1;
    g = 0;
    while (m_beat < 10 && g < 2000) begin
      @(negedge clk_sys);
      g++;
    end
    chk("t6_burst_started", 64'(m_beat >= 10), 64'd1);
    b0 = total_bursts;
    pulse_start();
    @(negedge clk_sys);
    chk("t6_ready_drain", {63'd0, pix_ready}, 64'd0);
    send_pix(128, 1'b0, 32'hA5000000);
    wait_drain();
    chk("t6_bursts", 64'(total_bursts - b0), 64'd2);
    chk("t6_new_addr", {35'd0, last_burst_addr}, {35'd0, BASE});
    chk("t6_new_beat0", first_din, 64'hA5000001_A5000000);
    chk("t6_leftover", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
